// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low idle patterns, the hex glyph
// table and the packed display word used by the scan driver.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dps;
  } disp_word_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_drv.sv
// Four-digit multiplexed seven-segment driver: frame-aligned value commit,
// anode dead-time on digit changes and optional leading-zero blanking.
module seg_scan_drv
  import seg7_pkg::*;
#(
  parameter int BLANK_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            msbs,
  input  logic [15:0]           din,
  input  logic [3:0]            dp_in,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame
);

  localparam int CW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [CW-1:0] BLANK_INIT = CW'(BLANK_CYC);

  disp_word_t            shadow_q, shadow_d;
  disp_word_t            pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic [1:0]            msbs_q, msbs_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  digit_chg, boundary, accept, commit;
  logic                  dead, lz_blank;
  logic [3:0]            cur_nib;
  logic [15:0]           upper;
  logic [6:0]            dec_seg;

  hex7seg u_dec (
    .hex (cur_nib),
    .seg (dec_seg)
  );

  assign din_ready = !pend_full_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign frame     = frame_q;

  always_comb begin
    digit_chg   = (msbs != msbs_q);
    boundary    = (msbs_q == 2'd3) && (msbs == 2'd0);
    accept      = din_valid && !pend_full_q;
    commit      = boundary && pend_full_q;

    shadow_d    = shadow_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    msbs_d      = msbs;
    frame_d     = commit;

    if (commit) begin
      shadow_d    = pend_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_d      = '{digits: din, dps: dp_in};
      pend_full_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (digit_chg) begin
      cnt_d = BLANK_INIT;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end

    // The change cycle itself is also dark so the old digit never overlaps
    // the new anode, giving BLANK_CYC+1 dark output cycles per digit step.
    dead     = (cnt_q != '0) || ((BLANK_CYC != 0) && digit_chg);
    cur_nib  = shadow_q.digits[{msbs_q, 2'b00} +: 4];
    upper    = shadow_q.digits >> {msbs_q, 2'b00};
    lz_blank = blank_lz && (msbs_q != 2'd0) && (upper == 16'h0000);

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!dead && !lz_blank) begin
      an_d  = ~(4'b0001 << msbs_q);
      seg_d = dec_seg;
      dp_d  = ~shadow_q.dps[msbs_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      msbs_q      <= '0;
      cnt_q       <= BLANK_INIT;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      msbs_q      <= msbs_d;
      cnt_q       <= cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Bench for seg_scan_drv: directed scan scenarios with literal expectations,
// then randomized refresh/data traffic checked every cycle against a model.
module tb_seg_scan_drv;

  localparam int BLANK_CYC = 4;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk;
  logic        rst;
  logic [1:0]  msbs;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        din_valid;
  logic        din_ready;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int checks = 0;
  int errors = 0;

  seg_scan_drv #(.BLANK_CYC(BLANK_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .msbs      (msbs),
    .din       (din),
    .dp_in     (dp_in),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame     (frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: tracks the displayed/pending words and how many edges
  // have elapsed since the digit select last moved.
  logic [15:0] m_shadow, m_pend;
  logic [3:0]  m_sdp, m_pend_dp;
  logic        m_pend_full;
  logic [1:0]  m_prev;
  int          m_since;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp, m_frame;

  logic        m_chg, m_bnd, m_acc, m_dark, m_lz;
  logic [3:0]  m_nib;

  always_comb begin
    m_chg  = (msbs != m_prev);
    m_bnd  = (m_prev == 2'd3) && (msbs == 2'd0);
    m_acc  = din_valid && !m_pend_full;
    m_dark = (BLANK_CYC > 0 && m_chg) || (m_since < BLANK_CYC);
    m_nib  = m_shadow[4*int'(m_prev) +: 4];
    m_lz   = blank_lz && (m_prev != 2'd0) && ((m_shadow >> (4*int'(m_prev))) == 16'h0);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_shadow    <= '0;
      m_sdp       <= '0;
      m_pend      <= '0;
      m_pend_dp   <= '0;
      m_pend_full <= 1'b0;
      m_prev      <= 2'd0;
      m_since     <= 0;
      m_an        <= 4'hF;
      m_seg       <= 7'h7F;
      m_dp        <= 1'b1;
      m_frame     <= 1'b0;
    end else begin
      if (m_dark || m_lz) begin
        m_an  <= 4'hF;
        m_seg <= 7'h7F;
        m_dp  <= 1'b1;
      end else begin
        m_an  <= ~(4'b0001 << m_prev);
        m_seg <= HEX_TAB[m_nib];
        m_dp  <= ~m_sdp[m_prev];
      end
      m_frame <= m_bnd && m_pend_full;
      if (m_bnd && m_pend_full) begin
        m_shadow    <= m_pend;
        m_sdp       <= m_pend_dp;
        m_pend_full <= 1'b0;
      end else if (m_acc) begin
        m_pend      <= din;
        m_pend_dp   <= dp_in;
        m_pend_full <= 1'b1;
      end
      m_since <= m_chg ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
      m_prev  <= msbs;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check_output("model an", {12'h0, an}, {12'h0, m_an});
      check_output("model seg", {9'h0, seg}, {9'h0, m_seg});
      check_output("model dp", {15'h0, dp}, {15'h0, m_dp});
      check_output("model frame", {15'h0, frame}, {15'h0, m_frame});
      check_output("model din_ready", {15'h0, din_ready}, {15'h0, !m_pend_full});
    end
  end

  logic       s_frame, s_ready1, s_ready2, s_dp;
  logic [3:0] s_an_early, s_an;
  logic [6:0] s_seg;

  // One 8-cycle refresh slot; samples taken on falling edges. din_valid is
  // dropped after the second edge of the slot.
  task automatic scan_slot(input logic [1:0] d);
    msbs = d;
    @(negedge clk);
    s_frame  = frame;
    s_ready1 = din_ready;
    @(negedge clk);
    s_ready2  = din_ready;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    s_an_early = an;
    @(negedge clk);
    s_an  = an;
    s_seg = seg;
    s_dp  = dp;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] p);
    din       = v;
    dp_in     = p;
    din_valid = 1'b1;
  endtask

  initial begin
    int hold;
    rst = 1'b1; msbs = 2'd0; din = '0; dp_in = '0; din_valid = 1'b0; blank_lz = 1'b0;
    #1 rst = 1'b0;
    #2;
    check_output("reset an", {12'h0, an}, 16'h000F);
    check_output("reset seg", {9'h0, seg}, 16'h007F);
    check_output("reset dp", {15'h0, dp}, 16'h0001);
    check_output("reset frame", {15'h0, frame}, 16'h0000);
    check_output("reset din_ready", {15'h0, din_ready}, 16'h0001);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Empty display scan
    scan_slot(2'd0);
    scan_slot(2'd1);
    check_output("scan d1 dead", {12'h0, s_an_early}, 16'h000F);
    check_output("scan d1 an", {12'h0, s_an}, 16'h000D);
    check_output("scan d1 seg", {9'h0, s_seg}, 16'h0040);
    scan_slot(2'd2);
    check_output("scan d2 an", {12'h0, s_an}, 16'h000B);
    scan_slot(2'd3);
    check_output("scan d3 an", {12'h0, s_an}, 16'h0007);
    scan_slot(2'd0);
    check_output("scan d0 an", {12'h0, s_an}, 16'h000E);
    check_output("scan d0 no frame", {15'h0, s_frame}, 16'h0000);

    // First word lands mid-frame, second word is held off until commit
    apply_stimulus(16'h12AF, 4'b0010);
    scan_slot(2'd1);
    check_output("w1 ready low", {15'h0, s_ready1}, 16'h0000);
    check_output("w1 not shown", {9'h0, s_seg}, 16'h0040);
    scan_slot(2'd2);
    scan_slot(2'd3);
    apply_stimulus(16'h3456, 4'b0001);
    @(negedge clk);
    msbs = 2'd3;
    check_output("w2 held off", {15'h0, din_ready}, 16'h0000);
    scan_slot(2'd0);
    check_output("w1 frame", {15'h0, s_frame}, 16'h0001);
    check_output("w2 ready after commit", {15'h0, s_ready1}, 16'h0001);
    check_output("w2 accepted", {15'h0, s_ready2}, 16'h0000);
    check_output("w1 d0 seg", {9'h0, s_seg}, 16'h000E);
    check_output("w1 d0 dp", {15'h0, s_dp}, 16'h0001);
    scan_slot(2'd1);
    check_output("w1 d1 seg", {9'h0, s_seg}, 16'h0008);
    check_output("w1 d1 dp", {15'h0, s_dp}, 16'h0000);
    scan_slot(2'd2);
    check_output("w1 d2 seg", {9'h0, s_seg}, 16'h0024);
    scan_slot(2'd3);
    check_output("w1 d3 seg", {9'h0, s_seg}, 16'h0079);
    scan_slot(2'd0);
    check_output("w2 frame", {15'h0, s_frame}, 16'h0001);
    check_output("w2 d0 seg", {9'h0, s_seg}, 16'h0002);
    check_output("w2 d0 dp", {15'h0, s_dp}, 16'h0000);

    // Leading-zero blanking on 0x0070
    blank_lz = 1'b1;
    apply_stimulus(16'h0070, 4'b0100);
    scan_slot(2'd1);
    scan_slot(2'd2);
    scan_slot(2'd3);
    scan_slot(2'd0);
    check_output("lz d0 an", {12'h0, s_an}, 16'h000E);
    check_output("lz d0 seg", {9'h0, s_seg}, 16'h0040);
    scan_slot(2'd1);
    check_output("lz d1 an", {12'h0, s_an}, 16'h000D);
    check_output("lz d1 seg", {9'h0, s_seg}, 16'h0078);
    scan_slot(2'd2);
    check_output("lz d2 an", {12'h0, s_an}, 16'h000F);
    check_output("lz d2 dp", {15'h0, s_dp}, 16'h0001);
    scan_slot(2'd3);
    check_output("lz d3 an", {12'h0, s_an}, 16'h000F);

    // Zero word accepted on the boundary edge itself commits one frame later
    apply_stimulus(16'h0000, 4'b0000);
    scan_slot(2'd0);
    check_output("bnd accept no frame", {15'h0, s_frame}, 16'h0000);
    check_output("bnd accept pending", {15'h0, s_ready1}, 16'h0000);
    scan_slot(2'd1);
    scan_slot(2'd2);
    scan_slot(2'd3);
    scan_slot(2'd0);
    check_output("bnd commit frame", {15'h0, s_frame}, 16'h0001);
    scan_slot(2'd1);
    check_output("zero d1 an", {12'h0, s_an}, 16'h000F);

    // Asynchronous reset with a digit lit and a pending word
    blank_lz = 1'b0;
    apply_stimulus(16'hBEEF, 4'b1111);
    scan_slot(2'd2);
    #2;
    rst  = 1'b0;
    msbs = 2'd0;
    #1;
    check_output("async an", {12'h0, an}, 16'h000F);
    check_output("async seg", {9'h0, seg}, 16'h007F);
    check_output("async dp", {15'h0, dp}, 16'h0001);
    check_output("async din_ready", {15'h0, din_ready}, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_output("post reset dead", {12'h0, an}, 16'h000F);
    @(negedge clk);
    check_output("post reset an", {12'h0, an}, 16'h000E);
    check_output("post reset seg", {9'h0, seg}, 16'h0040);

    // Randomized refresh counter with occasional jumps and random data
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 9) == 0) msbs = 2'($urandom_range(0, 3));
        else msbs = msbs + 2'd1;
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      din_valid = ($urandom_range(0, 3) == 0);
      din       = 16'($urandom);
      if ($urandom_range(0, 1) == 0) din = din & 16'h00FF;
      dp_in     = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
